// File: rtl/mux_4_to_1.sv
// Registered (or optionally combinational) 4-to-1 selector with capture enable,
// one-cycle valid flag and a record of the select used for the current output.
module mux_4_to_1 #(
    parameter int unsigned WIDTH      = 1,
    parameter int unsigned REGISTERED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [1:0]       sel_q
);

    logic [1:0]       sel;
    logic [WIDTH-1:0] mux_d;

    logic [WIDTH-1:0] data_d,    data_q;
    logic [1:0]       sel_cap_d, sel_cap_q;
    logic             valid_d,   valid_q;

    // An unknown select matches no case item, so the default spreads X onto the data.
    always_comb begin
        sel   = {s1, s0};
        mux_d = 'x;
        case (sel)
            2'b00:   mux_d = i0;
            2'b01:   mux_d = i1;
            2'b10:   mux_d = i2;
            2'b11:   mux_d = i3;
            default: mux_d = 'x;
        endcase
    end

    always_comb begin
        data_d    = data_q;
        sel_cap_d = sel_cap_q;
        valid_d   = en;
        if (en) begin
            data_d    = mux_d;
            sel_cap_d = sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            sel_cap_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            data_q    <= data_d;
            sel_cap_q <= sel_cap_d;
            valid_q   <= valid_d;
        end
    end

    // The register bank always exists; the parameter only chooses which view drives the ports.
    assign out       = (REGISTERED != 0) ? data_q    : mux_d;
    assign sel_q     = (REGISTERED != 0) ? sel_cap_q : (rst_n ? sel : 2'b00);
    assign out_valid = (REGISTERED != 0) ? valid_q   : (en & rst_n);

    sel_known_on_capture : assert property (
        @(posedge clk) disable iff (!rst_n)
        ((REGISTERED != 0) && en) |-> !$isunknown({s1, s0})
    );

endmodule

// File: tb/tb_mux_4_to_1.sv
// Scoreboard bench for mux_4_to_1: 8-bit registered, 1-bit registered and
// 8-bit combinational instances share one stimulus set.
module tb_mux_4_to_1;

    logic       clk = 1'b0;
    logic       rst_n, en, s0, s1;
    logic [7:0] i0, i1, i2, i3;

    logic [7:0] r_out;  logic r_valid; logic [1:0] r_sel;
    logic       w_out;  logic w_valid; logic [1:0] w_sel;
    logic [7:0] c_out;  logic c_valid; logic [1:0] c_sel;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [7:0] d;
        logic [1:0] s;
        logic       v;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_out;
    logic [1:0] m_sel;

    always #5 clk = ~clk;

    mux_4_to_1 #(.WIDTH(8), .REGISTERED(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .en(en),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3), .s0(s0), .s1(s1),
        .out(r_out), .out_valid(r_valid), .sel_q(r_sel)
    );

    mux_4_to_1 #(.WIDTH(1), .REGISTERED(1)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en),
        .i0(i0[0]), .i1(i1[0]), .i2(i2[0]), .i3(i3[0]), .s0(s0), .s1(s1),
        .out(w_out), .out_valid(w_valid), .sel_q(w_sel)
    );

    mux_4_to_1 #(.WIDTH(8), .REGISTERED(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3), .s0(s0), .s1(s1),
        .out(c_out), .out_valid(c_valid), .sel_q(c_sel)
    );

    // Drive one cycle of stimulus, push the expected registered result, and
    // return 1 ns after the capturing edge.
    task automatic step(input logic [1:0] sel, input logic e);
        exp_t       x;
        logic [7:0] ins [4];
        {s1, s0} = sel;
        en       = e;
        ins[0] = i0; ins[1] = i1; ins[2] = i2; ins[3] = i3;
        if (e) begin
            m_out = ins[sel];
            m_sel = sel;
        end
        x.d = m_out; x.s = m_sel; x.v = e;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; i0 = 8'h01; i1 = 8'h00; i2 = 8'h00; i3 = 8'h00;
        {s1, s0} = 2'b00;
        m_out = '0; m_sel = '0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            if ({r_out, r_sel, r_valid} !== 11'h000) begin
                mismatched++;
                $display("FAIL reset_hold%0d: out=%h sel=%b valid=%b want 00/00/0", n, r_out, r_sel, r_valid);
            end
            compared++;
            if ({w_out, w_sel, w_valid, c_valid} !== 5'b0) begin
                mismatched++;
                $display("FAIL reset_hold_w_c%0d: w_out=%b w_sel=%b w_valid=%b c_valid=%b want all 0",
                         n, w_out, w_sel, w_valid, c_valid);
            end
            compared++;
        end
        rst_n = 1'b1;
        i2 = 8'h3C;
        step(2'b10, 1'b1);
        begin
            exp_t x = sb.pop_front();
            if ({r_out, r_sel, r_valid} !== {x.d, x.s, x.v}) begin
                mismatched++;
                $display("FAIL first_capture: out=%h sel=%b valid=%b want %h/%b/%b", r_out, r_sel, r_valid, x.d, x.s, x.v);
            end
            compared++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        if ({r_out, r_sel, r_valid} !== 11'h000) begin
            mismatched++;
            $display("FAIL reset_async: out=%h sel=%b valid=%b want 00/00/0", r_out, r_sel, r_valid);
        end
        compared++;
        m_out = '0; m_sel = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        i0 = 8'h01; i1 = 8'h00; i2 = 8'h00; i3 = 8'h00;
        for (int k = 0; k < 4; k++) begin
            exp_t x;
            step(2'(k), 1'b1);
            x = sb.pop_front();
            if ({w_out, w_sel, w_valid} !== {x.d[0], x.s, x.v}) begin
                mismatched++;
                $display("FAIL sweep_w1_sel%0d: out=%b sel=%b valid=%b want %b/%b/%b", k, w_out, w_sel, w_valid, x.d[0], x.s, x.v);
            end
            compared++;
            if ({r_out, r_sel, r_valid} !== {x.d, x.s, x.v}) begin
                mismatched++;
                $display("FAIL sweep_w8_sel%0d: out=%h sel=%b valid=%b want %h/%b/%b", k, r_out, r_sel, r_valid, x.d, x.s, x.v);
            end
            compared++;
        end
    endtask

    task automatic test_walking_one();
        i0 = 8'h01; i1 = 8'h02; i2 = 8'h04; i3 = 8'h08;
        for (int k = 0; k < 5; k++) begin
            exp_t x;
            if (k == 4) i3 = 8'hFF;
            step(2'(k), 1'b1);
            x = sb.pop_front();
            if ({r_out, r_sel, r_valid} !== {x.d, x.s, x.v}) begin
                mismatched++;
                $display("FAIL walking_%0d: out=%h sel=%b valid=%b want %h/%b/%b", k, r_out, r_sel, r_valid, x.d, x.s, x.v);
            end
            compared++;
        end
    endtask

    task automatic test_hold();
        exp_t x;
        i2 = 8'hA5;
        step(2'b10, 1'b1);
        x = sb.pop_front();
        if ({r_out, r_sel, r_valid} !== {8'hA5, 2'b10, 1'b1}) begin
            mismatched++;
            $display("FAIL hold_capture: out=%h sel=%b valid=%b want a5/10/1", r_out, r_sel, r_valid);
        end
        compared++;
        for (int k = 0; k < 2; k++) begin
            i0 = 8'h11 + 8'(k); i1 = 8'h22; i2 = 8'h5A; i3 = 8'h77;
            step(2'(k), 1'b0);
            x = sb.pop_front();
            if ({r_out, r_sel, r_valid} !== {x.d, x.s, x.v}) begin
                mismatched++;
                $display("FAIL hold_%0d: out=%h sel=%b valid=%b want %h/%b/%b", k, r_out, r_sel, r_valid, x.d, x.s, x.v);
            end
            compared++;
        end
    endtask

    task automatic test_comb();
        logic [7:0] ins [4];
        i0 = 8'h01; i1 = 8'h02; i2 = 8'h04; i3 = 8'h08;
        ins[0] = 8'h01; ins[1] = 8'h02; ins[2] = 8'h04; ins[3] = 8'h08;
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            {s1, s0} = 2'(k);
            #1;
            if ({c_out, c_sel, c_valid} !== {ins[k], 2'(k), 1'b1}) begin
                mismatched++;
                $display("FAIL comb_sel%0d: out=%h sel=%b valid=%b want %h/%b/1", k, c_out, c_sel, c_valid, ins[k], 2'(k));
            end
            compared++;
        end
        en = 1'b0;
        #0.5;
        if (c_valid !== 1'b0 || r_out !== m_out) begin
            mismatched++;
            $display("FAIL comb_en_low: c_valid=%b r_out=%h want 0 and %h", c_valid, r_out, m_out);
        end
        compared++;
    endtask

    task automatic test_simultaneous();
        exp_t x;
        i0 = 8'h00; i3 = 8'h00;
        step(2'b00, 1'b1);
        x = sb.pop_front();
        if (r_out !== x.d) begin
            mismatched++;
            $display("FAIL simul_pre: out=%h want %h", r_out, x.d);
        end
        compared++;
        i3 = 8'h01;
        step(2'b11, 1'b1);
        x = sb.pop_front();
        if ({r_out, r_sel, r_valid} !== {8'h01, 2'b11, 1'b1} || w_out !== 1'b1) begin
            mismatched++;
            $display("FAIL simul_change: out=%h sel=%b valid=%b w_out=%b want 01/11/1 w 1", r_out, r_sel, r_valid, w_out);
        end
        compared++;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            exp_t x;
            i0 = 8'($urandom); i1 = 8'($urandom); i2 = 8'($urandom); i3 = 8'($urandom);
            step(2'($urandom_range(0, 3)), 1'b1);
            x = sb.pop_front();
            if ({r_out, r_sel, r_valid} !== {x.d, x.s, x.v} || {w_out, w_valid} !== {x.d[0], 1'b1}) begin
                mismatched++;
                $display("FAIL b2b_%0d: out=%h sel=%b valid=%b w=%b/%b want %h/%b/%b w %b/1",
                         k, r_out, r_sel, r_valid, w_out, w_valid, x.d, x.s, x.v, x.d[0]);
            end
            compared++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sweep();
        test_walking_one();
        test_hold();
        test_comb();
        test_simultaneous();
        test_back_to_back();
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
        end
        compared++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
